// File: rtl/crc16_pkg.sv
// crc16_pkg
// Shared definitions for the CRC-16 frame controller slice.
//   POLY_MODBUS : reflected CRC-16/MODBUS polynomial (right-shift form)
//   INIT_MODBUS : CRC register preset applied at the start of every frame
//   state_t     : frame controller FSM states
//   byte_swap   : helper that produces the transmit-order CRC word
package crc16_pkg;

  localparam logic [15:0] POLY_MODBUS = 16'hA001;
  localparam logic [15:0] INIT_MODBUS = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // The low CRC byte goes on the wire first, so the presented word is swapped.
  function automatic logic [15:0] byte_swap(input logic [15:0] value);
    return {value[7:0], value[15:8]};
  endfunction

endpackage

// File: rtl/crc16_bit_step.sv
// crc16_bit_step
// One bit of a reflected (LSB-first) CRC-16: shift right with zero fill,
// then XOR the polynomial if the bit shifted out was a 1.
// Ports:
//   crc_in   [15:0] in  : current CRC register
//   poly     [15:0] in  : reflected polynomial
//   crc_next [15:0] out : CRC register after one bit step
module crc16_bit_step (
  input  logic [15:0] crc_in,
  input  logic [15:0] poly,
  output logic [15:0] crc_next
);

  always_comb begin
    crc_next = {1'b0, crc_in[15:1]};
    if (crc_in[0]) begin
      crc_next = crc_next ^ poly;
    end
  end

endmodule

// File: rtl/crc16_frame_ctrl.sv
// crc16_frame_ctrl
// Byte-serial CRC-16 over a frame, one bit per clock. Each accepted byte is
// folded into the low CRC byte and then shifted for 8 cycles; after the final
// byte of a frame the result is presented with a one-cycle crc_valid pulse and
// the register re-presets itself for the next frame.
// Parameters:
//   POLY : reflected polynomial (default CRC-16/MODBUS)
//   INIT : CRC preset value at frame start
// Ports:
//   clk            in  : clock, rising edge
//   rst            in  : asynchronous, active-low reset
//   start          in  : abort current frame and re-preset the CRC
//   in_valid       in  : in_data / in_last valid
//   in_data  [7:0] in  : frame byte
//   in_last        in  : in_data is the final byte of the frame
//   in_ready       out : a byte can be accepted this cycle
//   busy           out : shifting a byte or presenting a result
//   crc_valid      out : one-cycle pulse, new result on crc_out / crc_raw
//   crc_out [15:0] out : final CRC, bytes swapped
//   crc_raw [15:0] out : final CRC register value
module crc16_frame_ctrl
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = POLY_MODBUS,
  parameter logic [15:0] INIT = INIT_MODBUS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        busy,
  output logic        crc_valid,
  output logic [15:0] crc_out,
  output logic [15:0] crc_raw
);

  state_t      state;
  logic [15:0] crc_reg;
  logic [15:0] step_next;
  logic [2:0]  bit_cnt;
  logic        last_flag;

  crc16_bit_step u_bit_step (
    .crc_in   (crc_reg),
    .poly     (POLY),
    .crc_next (step_next)
  );

  // start has priority over a byte, so it must also hide in_ready in the same
  // cycle; rst gating keeps in_ready low for the whole reset period.
  assign in_ready = rst && (state == IDLE) && !start;
  assign busy     = (state != IDLE);

  // crc_valid is registered and set on the transition into DONE, so it is
  // high exactly for the single DONE cycle. A start in the last SHIFT cycle
  // therefore prevents the pulse from ever appearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      crc_reg   <= INIT;
      bit_cnt   <= 3'd0;
      last_flag <= 1'b0;
      crc_valid <= 1'b0;
      crc_out   <= 16'h0000;
      crc_raw   <= 16'h0000;
    end else begin
      crc_valid <= 1'b0;
      if (start) begin
        state     <= IDLE;
        crc_reg   <= INIT;
        bit_cnt   <= 3'd0;
        last_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              crc_reg   <= crc_reg ^ {8'h00, in_data};
              bit_cnt   <= 3'd0;
              last_flag <= in_last;
              state     <= SHIFT;
            end
          end
          SHIFT: begin
            crc_reg <= step_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (last_flag) begin
                state     <= DONE;
                crc_valid <= 1'b1;
                crc_raw   <= step_next;
                crc_out   <= byte_swap(step_next);
              end else begin
                state <= IDLE;
              end
            end
          end
          DONE: begin
            // Auto-preset so the next frame needs no start pulse.
            crc_reg   <= INIT;
            last_flag <= 1'b0;
            state     <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
